// File: rtl/bram_fifo_pkg.sv
// Shared constants and sizing helpers for the BRAM-backed FIFO controller.
// Imported by the controller top and its output buffer.
package bram_fifo_pkg;

    localparam int OB_DEPTH = 2;
    localparam int OB_CNT_W = $clog2(OB_DEPTH + 1);

    // Level counts BRAM words plus one read in flight plus the output buffer.
    function automatic int levelWidth(input int addrWidth);
        return $clog2((1 << addrWidth) + 3);
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_out_buffer.sv
// Two-entry registered output stage; absorbs the BRAM read latency so that the
// consumer sees back-to-back words.
module fifo_out_buffer
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OB_CNT_W-1:0]   count
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [OB_CNT_W-1:0]   count_q, count_d;
    logic                  pop;

    assign out_valid = (count_q != '0);
    assign out_data  = head_q;
    assign count     = count_q;
    assign pop       = out_valid & out_ready;

    // The upstream issue logic never delivers a word into a full buffer
    // unless the head is leaving in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            OB_CNT_W'(0): begin
                if (in_valid) begin
                    head_d  = in_data;
                    count_d = OB_CNT_W'(1);
                end
            end
            OB_CNT_W'(1): begin
                if (pop && in_valid) begin
                    head_d = in_data;
                end else if (pop) begin
                    count_d = OB_CNT_W'(0);
                end else if (in_valid) begin
                    tail_d  = in_data;
                    count_d = OB_CNT_W'(2);
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (in_valid) begin
                        tail_d = in_data;
                    end else begin
                        count_d = OB_CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller sequencing an external simple dual-port BRAM with a registered
// read port; a small output buffer keeps the read side streaming at one word per cycle.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_write_addr,
    output logic [DATA_WIDTH-1:0] bram_write_data,
    output logic [ADDR_WIDTH-1:0] bram_read_addr,
    input  logic [DATA_WIDTH-1:0] bram_read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LVL_W = levelWidth(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   memCount_q, memCount_d;
    logic                  rdPend_q, rdPend_d;
    logic [LVL_W-1:0]      level_q, level_d;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            obOccupancy;
    logic [OB_CNT_W-1:0]   obCount;
    logic                  obValid;
    logic [DATA_WIDTH-1:0] obData;

    assign s_ready = rst_n & ~clr & (memCount_q < (ADDR_WIDTH+1)'(DEPTH));
    assign push    = s_valid & s_ready;
    assign pop     = obValid & m_ready;

    // A read is only issued when the buffer is guaranteed a free slot at capture
    // time; memCount_q excludes this cycle's write, so the written address is never read back early.
    assign obOccupancy = 3'(obCount) + 3'(rdPend_q) - 3'(pop);
    assign issue       = (memCount_q != '0) & (obOccupancy < 3'd2) & ~clr;

    assign bram_wr_en      = push;
    assign bram_write_addr = wrPtr_q;
    assign bram_write_data = s_data;
    assign bram_read_addr  = rdPtr_q;

    assign m_valid = obValid;
    assign m_data  = obData;
    assign level   = (ADDR_WIDTH+2)'(level_q);

    always_comb begin
        wrPtr_d    = wrPtr_q + ADDR_WIDTH'(push);
        rdPtr_d    = rdPtr_q + ADDR_WIDTH'(issue);
        memCount_d = memCount_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
        rdPend_d   = issue;
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            memCount_q <= '0;
            rdPend_q   <= 1'b0;
            level_q    <= '0;
        end else if (clr) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            memCount_q <= '0;
            rdPend_q   <= 1'b0;
            level_q    <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            memCount_q <= memCount_d;
            rdPend_q   <= rdPend_d;
            level_q    <= level_d;
        end
    end

    fifo_out_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (rdPend_q),
        .in_data   (bram_read_data),
        .out_valid (obValid),
        .out_ready (m_ready),
        .out_data  (obData),
        .count     (obCount)
    );

endmodule
